// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the rv32i_sc load/store unit.
// Holds funct3 access encodings, FSM states and store-lane helpers.
package load_store_unit_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Loads may use all five encodings; stores only B/H/W.
    function automatic logic f3_legal(input logic [2:0] f3,
                                      input logic       is_store);
        logic ok;
        case (f3)
            LS_B, LS_H, LS_W: ok = 1'b1;
            LS_BU, LS_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte offset actually used inside the word: halfwords drop
    // a[0], words drop a[1:0] (misaligned accesses fold to aligned).
    function automatic logic [1:0] lane_off(input logic [2:0] f3,
                                            input logic [1:0] a);
        logic [1:0] off;
        case (f3)
            LS_H, LS_HU: off = {a[1], 1'b0};
            LS_W:        off = 2'b00;
            default:     off = a;
        endcase
        return off;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        case (f3)
            LS_H, LS_HU: bad = a[0];
            LS_W:        bad = |a;
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            LS_B:    s = 4'b0001 << off;
            LS_H:    s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            LS_B:    w = {4{d[7:0]}};
            LS_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_store_unit_load.sv
// Combinational load lane select and sign/zero extension.
// Module lsu_load_align; shared with the verification model.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    assign w_shift = i_rdata >> {i_off, 3'b000};

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        o_data = w_shift;
        case (i_funct3)
            LS_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            LS_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            LS_BU:   o_data = {24'd0, w_shift[7:0]};
            LS_HU:   o_data = {16'd0, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of rv32i_sc: one load/store per accept on dmem.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    lsu_state_e  r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_start;
    logic        w_accept;
    logic        w_store;
    logic        w_bad;
    logic        w_mis;
    logic [1:0]  w_off;
    logic        w_timeout;
    logic [31:0] w_load;

    assign w_start  = ex_valid & (ex_mem_read | ex_mem_write);
    assign w_accept = ex_valid & (ex_mem_read ^ ex_mem_write);
    assign w_store  = ex_mem_write;
    assign w_off    = lane_off(ex_funct3, ex_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis = misaligned(ex_funct3, ex_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_bad = (ex_mem_read & ex_mem_write)
                 | !f3_legal(ex_funct3, w_store)
                 | w_mis;

    assign w_timeout = (r_cnt == TO_LAST);

    // Stall covers the accept cycle and every bus cycle.
    assign lsu_stall = (r_state == ST_REQ)
                     | (r_state == ST_RESP)
                     | ((r_state == ST_IDLE) & w_accept);

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wstrb = r_wstrb;
    assign dmem_wdata = r_wdata;
    assign lsu_done   = r_done;
    assign lsu_err    = r_err;
    assign lsu_rdata  = r_rdata;

    lsu_load_align u_align (
        .i_rdata  (dmem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_load)
    );

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state <= ST_REQ;
                            r_cnt   <= 8'd0;
                            r_req   <= 1'b1;
                            r_we    <= w_store;
                            r_f3    <= ex_funct3;
                            r_off   <= w_off;
                            r_addr  <= {ex_addr[31:2], 2'b00};
                            r_wstrb <= w_store
                                     ? store_strb(ex_funct3, w_off)
                                     : 4'd0;
                            r_wdata <= w_store
                                     ? store_data(ex_funct3, ex_wdata)
                                     : 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_ready) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'd0;
                        r_cnt   <= r_cnt + 8'd1;
                        if (r_we) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'd0;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (BUS_TIMEOUT=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BUS_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .lsu_stall    (lsu_stall),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .lsu_rdata    (lsu_rdata),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = a;
        ex_wdata     = d;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Store with memory ready in the first REQ cycle.
    task automatic store_fast(input string tag, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] e_addr,
                              input logic [3:0] e_strb,
                              input logic [31:0] e_wdata);
        @(negedge clk);
        dmem_ready = 1'b1;
        issue(1'b0, 1'b1, f3, a, d);
        #1 chk({tag, "_stall0"}, lsu_stall, 1);
        @(negedge clk);
        idle_ex();
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, 1);
        chk({tag, "_addr"}, dmem_addr, e_addr);
        chk({tag, "_strb"}, dmem_wstrb, e_strb);
        chk({tag, "_wdata"}, dmem_wdata, e_wdata);
        chk({tag, "_stall1"}, lsu_stall, 1);
        @(negedge clk);
        chk({tag, "_done"}, lsu_done, 1);
        chk({tag, "_err"}, lsu_err, 0);
        chk({tag, "_stall2"}, lsu_stall, 0);
        chk({tag, "_reqlo"}, dmem_req, 0);
    endtask

    // Load with ready in REQ and rvalid in the first RESP cycle.
    task automatic load_fast(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] e_addr,
                             input logic [31:0] word,
                             input logic [31:0] e_data);
        @(negedge clk);
        dmem_ready = 1'b1;
        issue(1'b1, 1'b0, f3, a, 32'h0);
        #1 chk({tag, "_stall0"}, lsu_stall, 1);
        @(negedge clk);
        idle_ex();
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, 0);
        chk({tag, "_strb"}, dmem_wstrb, 0);
        chk({tag, "_addr"}, dmem_addr, e_addr);
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        @(negedge clk);
        chk({tag, "_resp_stall"}, lsu_stall, 1);
        chk({tag, "_resp_req"}, dmem_req, 0);
        chk({tag, "_resp_done"}, lsu_done, 0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk({tag, "_done"}, lsu_done, 1);
        chk({tag, "_err"}, lsu_err, 0);
        chk({tag, "_rdata"}, lsu_rdata, e_data);
        chk({tag, "_stall3"}, lsu_stall, 0);
    endtask

    // Access rejected in IDLE: error pulse without bus activity.
    task automatic reject(input string tag, input logic rd,
                          input logic wr, input logic [2:0] f3,
                          input logic [31:0] a);
        @(negedge clk);
        dmem_ready = 1'b1;
        issue(rd, wr, f3, a, 32'h1234_5678);
        @(negedge clk);
        idle_ex();
        chk({tag, "_done"}, lsu_done, 1);
        chk({tag, "_err"}, lsu_err, 1);
        chk({tag, "_req"}, dmem_req, 0);
        chk({tag, "_rdata"}, lsu_rdata, 0);
        @(negedge clk);
        chk({tag, "_idle"}, lsu_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        idle_ex();
        ex_funct3   = 3'd0;
        ex_addr     = 32'd0;
        ex_wdata    = 32'd0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;

        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_err", lsu_err, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_strb", dmem_wstrb, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_stall", lsu_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        store_fast("sw", LS_W, 32'h100, 32'hDEAD_BEEF,
                   32'h100, 4'b1111, 32'hDEAD_BEEF);
        store_fast("sb", LS_B, 32'h103, 32'h0000_00A5,
                   32'h100, 4'b1000, 32'hA5A5_A5A5);
        store_fast("sh", LS_H, 32'h102, 32'h1234_BEEF,
                   32'h100, 4'b1100, 32'hBEEF_BEEF);

        load_fast("lb", LS_B, 32'h102, 32'h100,
                  32'h0080_FF00, 32'hFFFF_FF80);
        load_fast("lbu", LS_BU, 32'h102, 32'h100,
                  32'h0080_FF00, 32'h0000_0080);
        load_fast("lhu", LS_HU, 32'h102, 32'h100,
                  32'h0080_FF00, 32'h0000_0080);
        load_fast("lh", LS_H, 32'h200, 32'h200,
                  32'hABCD_7FFF, 32'h0000_7FFF);
        load_fast("lb1", LS_B, 32'h201, 32'h200,
                  32'h0000_7F00, 32'h0000_007F);
        load_fast("lw", LS_W, 32'h300, 32'h300,
                  32'hCAFE_F00D, 32'hCAFE_F00D);

        // Ready held low for 3 REQ cycles, high on the 4th.
        @(negedge clk);
        dmem_ready = 1'b0;
        issue(1'b0, 1'b1, LS_W, 32'h240, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_ex();
            chk("slow_req", dmem_req, 1);
            chk("slow_addr", dmem_addr, 32'h240);
            chk("slow_wdata", dmem_wdata, 32'h0BAD_F00D);
            chk("slow_done", lsu_done, 0);
            if (i == 3) dmem_ready = 1'b1;
        end
        @(negedge clk);
        chk("slow_fin_done", lsu_done, 1);
        chk("slow_fin_err", lsu_err, 0);
        chk("slow_fin_req", dmem_req, 0);
        @(negedge clk);
        chk("slow_single", dmem_req, 0);

        // Memory never ready: abort after 4 REQ cycles.
        @(negedge clk);
        dmem_ready = 1'b0;
        issue(1'b1, 1'b0, LS_W, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_ex();
            chk("to_req", dmem_req, 1);
            chk("to_done", lsu_done, 0);
        end
        @(negedge clk);
        chk("to_fin_done", lsu_done, 1);
        chk("to_fin_err", lsu_err, 1);
        chk("to_fin_rdata", lsu_rdata, 0);
        chk("to_fin_req", dmem_req, 0);
        chk("to_fin_stall", lsu_stall, 0);

        reject("ill_ld", 1'b1, 1'b0, 3'b011, 32'h100);
        reject("ill_st", 1'b0, 1'b1, LS_BU, 32'h100);
        reject("rdwr", 1'b1, 1'b1, LS_W, 32'h100);

        // Reset while waiting for read data.
        @(negedge clk);
        dmem_ready = 1'b1;
        issue(1'b1, 1'b0, LS_W, 32'h100, 32'h0);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        chk("rresp_stall", lsu_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rresp_req", dmem_req, 0);
        chk("rresp_stall0", lsu_stall, 0);
        chk("rresp_addr", dmem_addr, 0);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        @(negedge clk);
        chk("rresp_nodone", lsu_done, 0);
        chk("rresp_idle", lsu_stall, 0);
        dmem_rvalid = 1'b0;

        // Reset while the request is outstanding.
        @(negedge clk);
        dmem_ready = 1'b0;
        issue(1'b0, 1'b1, LS_W, 32'h400, 32'h5555_AAAA);
        @(negedge clk);
        idle_ex();
        chk("rreq_req1", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rreq_req0", dmem_req, 0);
        chk("rreq_wdata", dmem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
        reject("mis_lw", 1'b1, 1'b0, LS_W, 32'h102);
        reject("mis_sh", 1'b0, 1'b1, LS_H, 32'h101);
`else
        load_fast("mis_lw", LS_W, 32'h102, 32'h100,
                  32'h1234_5678, 32'h1234_5678);
        load_fast("mis_lh", LS_H, 32'h103, 32'h100,
                  32'h8001_0000, 32'hFFFF_8001);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
